// File: rtl/mdu_sched_if.sv
// E-stage <-> multiply/divide sequencer signal bundle.
// The master side is the pipeline; the slave side is mdu_sched.
interface mdu_sched_if;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned OP_W   = 4;
    localparam int unsigned CNT_W  = 4;

    logic              start;
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] src_a;
    logic [DATA_W-1:0] src_b;
    logic              md_in_d;
    logic              busy;
    logic              stall_md;
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;
    logic [CNT_W-1:0]  count;

    modport master (
        output start, op, src_a, src_b, md_in_d,
        input  busy, stall_md, hi, lo, count
    );

    modport slave (
        input  start, op, src_a, src_b, md_in_d,
        output busy, stall_md, hi, lo, count
    );
endinterface

// File: rtl/mdu_sched.sv
// Multiply/divide sequencer: latches the result at issue, counts down a fixed
// per-class latency, then commits HI/LO. Also raises the D-stage MDU stall.
module mdu_sched #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    mdu_sched_if.slave  bus
);
    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 4;

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t              r_state,   w_state_nxt;
    logic [CNT_W-1:0]    r_count,   w_count_nxt;
    logic [DATA_W-1:0]   r_hi,      w_hi_nxt;
    logic [DATA_W-1:0]   r_lo,      w_lo_nxt;
    logic [DATA_W-1:0]   r_res_hi,  w_res_hi_nxt;
    logic [DATA_W-1:0]   r_res_lo,  w_res_lo_nxt;
    logic                r_res_ok,  w_res_ok_nxt;

    logic                w_issue;
    logic                w_is_mul;
    logic                w_b_zero;
    logic [2*DATA_W-1:0] w_prod_s;
    logic [2*DATA_W-1:0] w_prod_u;
    logic [DATA_W-1:0]   w_divisor;
    logic signed [DATA_W-1:0] w_quo_s;
    logic signed [DATA_W-1:0] w_rem_s;
    logic [DATA_W-1:0]   w_quo_u;
    logic [DATA_W-1:0]   w_rem_u;

    assign w_issue  = bus.start && (bus.op >= OP_MULT) && (bus.op <= OP_DIVU);
    assign w_is_mul = (bus.op == OP_MULT) || (bus.op == OP_MULTU);
    assign w_b_zero = (bus.src_b == '0);

    // Low 64 bits of a product of sign-extended operands equal the signed product.
    assign w_prod_s = {{DATA_W{bus.src_a[DATA_W-1]}}, bus.src_a} *
                      {{DATA_W{bus.src_b[DATA_W-1]}}, bus.src_b};
    assign w_prod_u = {{DATA_W{1'b0}}, bus.src_a} * {{DATA_W{1'b0}}, bus.src_b};

    // Divisor forced to 1 on zero so the dividers never see /0; result is discarded anyway.
    assign w_divisor = w_b_zero ? DATA_W'(1) : bus.src_b;
    assign w_quo_s   = $signed(bus.src_a) / $signed(w_divisor);
    assign w_rem_s   = $signed(bus.src_a) % $signed(w_divisor);
    assign w_quo_u   = bus.src_a / w_divisor;
    assign w_rem_u   = bus.src_a % w_divisor;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_count  <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_res_hi <= '0;
            r_res_lo <= '0;
            r_res_ok <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_count  <= w_count_nxt;
            r_hi     <= w_hi_nxt;
            r_lo     <= w_lo_nxt;
            r_res_hi <= w_res_hi_nxt;
            r_res_lo <= w_res_lo_nxt;
            r_res_ok <= w_res_ok_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_count_nxt  = r_count;
        w_hi_nxt     = r_hi;
        w_lo_nxt     = r_lo;
        w_res_hi_nxt = r_res_hi;
        w_res_lo_nxt = r_res_lo;
        w_res_ok_nxt = r_res_ok;

        case (r_state)
            ST_IDLE: begin
                if (w_issue) begin
                    w_state_nxt  = ST_RUN;
                    w_count_nxt  = w_is_mul ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
                    w_res_ok_nxt = 1'b1;
                    case (bus.op)
                        OP_MULT:  {w_res_hi_nxt, w_res_lo_nxt} = w_prod_s;
                        OP_MULTU: {w_res_hi_nxt, w_res_lo_nxt} = w_prod_u;
                        OP_DIV: begin
                            w_res_lo_nxt = w_quo_s;
                            w_res_hi_nxt = w_rem_s;
                            w_res_ok_nxt = !w_b_zero;
                        end
                        OP_DIVU: begin
                            w_res_lo_nxt = w_quo_u;
                            w_res_hi_nxt = w_rem_u;
                            w_res_ok_nxt = !w_b_zero;
                        end
                        default: ;
                    endcase
                end else if (!bus.start && bus.op == OP_MTHI) begin
                    w_hi_nxt = bus.src_a;
                end else if (!bus.start && bus.op == OP_MTLO) begin
                    w_lo_nxt = bus.src_a;
                end
            end
            ST_RUN: begin
                // New starts and mthi/mtlo are dropped while the countdown runs.
                w_count_nxt = r_count - CNT_W'(1);
                if (r_count == CNT_W'(1)) begin
                    w_state_nxt = ST_IDLE;
                    if (r_res_ok) begin
                        w_hi_nxt = r_res_hi;
                        w_lo_nxt = r_res_lo;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign bus.busy     = (r_state == ST_RUN);
    assign bus.count    = r_count;
    assign bus.hi       = r_hi;
    assign bus.lo       = r_lo;
    assign bus.stall_md = bus.md_in_d & ((r_state == ST_RUN) | bus.start);
endmodule

// File: tb/tb_mdu_sched.sv
// Self-checking bench for mdu_sched: directed scenarios plus random traffic
// compared each cycle against a countdown/arithmetic reference model.
module tb_mdu_sched;
    localparam int unsigned MULT_N = 5;
    localparam int unsigned DIV_N  = 10;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mdu_sched_if bus();

    mdu_sched #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: remaining cycles, architectural HI/LO, pending result.
    int          m_left = 0;
    logic [31:0] m_hi = '0, m_lo = '0, m_phi = '0, m_plo = '0;
    bit          m_pv = 1'b0;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_edge(input bit rst, input bit st, input logic [3:0] o,
                              input logic [31:0] a, input logic [31:0] b);
        longint          p;
        longint unsigned pu;
        int              sa, sb, q;
        if (rst) begin
            m_left = 0; m_hi = '0; m_lo = '0; m_phi = '0; m_plo = '0; m_pv = 1'b0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0 && m_pv) begin
                m_hi = m_phi;
                m_lo = m_plo;
            end
        end else if (st && o >= 4'd1 && o <= 4'd4) begin
            m_left = (o <= 4'd2) ? MULT_N : DIV_N;
            m_pv   = 1'b1;
            sa = int'(a);
            sb = int'(b);
            case (o)
                4'd1: begin p = longint'(sa) * longint'(sb); {m_phi, m_plo} = p; end
                4'd2: begin pu = {32'b0, a} * {32'b0, b}; {m_phi, m_plo} = pu; end
                4'd3: begin
                    if (b == 0) m_pv = 1'b0;
                    else begin q = sa / sb; m_plo = q; m_phi = sa - q * sb; end
                end
                default: begin
                    if (b == 0) m_pv = 1'b0;
                    else begin m_plo = a / b; m_phi = a - (a / b) * b; end
                end
            endcase
        end else if (!st && o == 4'd5) begin
            m_hi = a;
        end else if (!st && o == 4'd6) begin
            m_lo = a;
        end
    endtask

    // One clock: drive inputs, check the combinational stall, clock, check registered outputs.
    task automatic cyc(input bit rst, input bit st, input logic [3:0] o,
                       input logic [31:0] a, input logic [31:0] b, input bit md);
        reset = rst; bus.start = st; bus.op = o; bus.src_a = a; bus.src_b = b; bus.md_in_d = md;
        #1;
        check_eq("stall_md", 64'(bus.stall_md), 64'(md & ((m_left > 0) | st)));
        @(posedge clk);
        model_edge(rst, st, o, a, b);
        #1;
        check_eq("busy",  64'(bus.busy),  64'(m_left > 0));
        check_eq("count", 64'(bus.count), 64'(m_left));
        check_eq("hi",    64'(bus.hi),    64'(m_hi));
        check_eq("lo",    64'(bus.lo),    64'(m_lo));
    endtask

    task automatic idle(input int n, input bit md);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 4'd0, 32'h0, 32'h0, md);
    endtask

    initial begin
        logic [31:0] ra, rb;
        logic [3:0]  ro;
        bit          rst, st;

        cyc(1'b1, 1'b0, 4'd0, 32'h0, 32'h0, 1'b0);
        cyc(1'b1, 1'b0, 4'd0, 32'h0, 32'h0, 1'b0);
        check_eq("reset_count", 64'(bus.count), 64'd0);

        // Signed multiply -2 * 3.
        cyc(1'b0, 1'b1, 4'd1, 32'hFFFF_FFFE, 32'd3, 1'b0);
        idle(MULT_N, 1'b0);
        check_eq("tp_mult_hi", 64'(bus.hi), 64'hFFFF_FFFF);
        check_eq("tp_mult_lo", 64'(bus.lo), 64'hFFFF_FFFA);

        // Unsigned multiply, then signed divide -7 / 2.
        cyc(1'b0, 1'b1, 4'd2, 32'hFFFF_FFFF, 32'd2, 1'b0);
        idle(MULT_N, 1'b0);
        check_eq("tp_multu_hi", 64'(bus.hi), 64'h1);
        check_eq("tp_multu_lo", 64'(bus.lo), 64'hFFFF_FFFE);
        cyc(1'b0, 1'b1, 4'd3, 32'hFFFF_FFF9, 32'd2, 1'b0);
        idle(DIV_N, 1'b0);
        check_eq("tp_div_lo", 64'(bus.lo), 64'hFFFF_FFFD);
        check_eq("tp_div_hi", 64'(bus.hi), 64'hFFFF_FFFF);

        // mthi/mtlo then divide by zero leaves HI/LO untouched.
        cyc(1'b0, 1'b0, 4'd5, 32'h1234, 32'h0, 1'b0);
        cyc(1'b0, 1'b0, 4'd6, 32'h5678, 32'h0, 1'b0);
        cyc(1'b0, 1'b1, 4'd4, 32'd10, 32'd0, 1'b0);
        idle(DIV_N, 1'b0);
        check_eq("tp_dz_hi", 64'(bus.hi), 64'h1234);
        check_eq("tp_dz_lo", 64'(bus.lo), 64'h5678);

        // Stall request with and without a D-stage MDU instruction.
        cyc(1'b0, 1'b1, 4'd1, 32'd3, 32'd4, 1'b1);
        idle(MULT_N + 1, 1'b1);
        cyc(1'b0, 1'b1, 4'd1, 32'd5, 32'd6, 1'b0);
        idle(MULT_N, 1'b0);

        // Reset aborts a divide at count 3; a later multiply completes.
        cyc(1'b0, 1'b1, 4'd3, 32'd100, 32'd7, 1'b0);
        idle(DIV_N - 3, 1'b0);
        check_eq("tp_abort_cnt", 64'(bus.count), 64'd3);
        cyc(1'b1, 1'b0, 4'd0, 32'h0, 32'h0, 1'b0);
        check_eq("tp_abort_hi", 64'(bus.hi), 64'h0);
        cyc(1'b0, 1'b1, 4'd1, 32'd6, 32'd7, 1'b0);
        idle(MULT_N, 1'b0);
        check_eq("tp_after_abort_lo", 64'(bus.lo), 64'd42);

        // Start and mthi while busy are ignored.
        cyc(1'b0, 1'b1, 4'd1, 32'd5, 32'd5, 1'b0);
        idle(MULT_N - 3, 1'b0);
        cyc(1'b0, 1'b1, 4'd1, 32'd99, 32'd99, 1'b0);
        cyc(1'b0, 1'b0, 4'd5, 32'hDEAD_BEEF, 32'h0, 1'b0);
        idle(1, 1'b0);
        check_eq("tp_ign_hi", 64'(bus.hi), 64'h0);
        check_eq("tp_ign_lo", 64'(bus.lo), 64'd25);

        // Random traffic, including illegal starts during a countdown.
        for (int i = 0; i < 1500; i++) begin
            rst = ($urandom % 64) == 0;
            st  = (m_left == 0) ? (($urandom % 3) == 0) : (($urandom % 16) == 0);
            ro  = ($urandom % 8 == 0) ? 4'($urandom % 16) : 4'($urandom % 8);
            ra  = ($urandom % 4 == 0) ? 32'($urandom % 32) : 32'($urandom);
            case ($urandom % 5)
                0:       rb = 32'h0;
                1:       rb = 32'($urandom % 16);
                2:       rb = -32'($urandom % 16);
                default: rb = 32'($urandom);
            endcase
            if (ra == 32'h8000_0000 && rb == 32'hFFFF_FFFF) rb = 32'd1;
            cyc(rst, st, ro, ra, rb, 1'($urandom % 2));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/mdu_sched.md
Name: mdu_sched

Overview:
Sequencing controller for the pipeline's multiply/divide resource and its HI/LO registers.
- Accepts one operation per cycle from the E stage.
- Latches operands at issue and runs a fixed-latency busy countdown per operation class.
- Commits HI/LO on completion.
- Raises a D-stage stall request so a following MDU-class instruction waits until the unit is free.
- Sits beside the ALU in E; hi/lo feed the E-stage result mux for mfhi/mflo.

Parameters:
MULT_CYCLES, 5, busy cycles for mult/multu (1..15)
DIV_CYCLES, 10, busy cycles for div/divu (1..15)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
start  input  1  E-stage issue strobe for mult/multu/div/divu, one cycle
op  input  4  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, others none
src_a  input  32  forwarded rs value (E stage)
src_b  input  32  forwarded rt value (E stage)
md_in_d  input  1  D-stage instruction is MDU-class (mult..mtlo, mfhi, mflo)
busy  output  1  countdown in progress
stall_md  output  1  stall request to hazard unit
hi  output  32  HI register
lo  output  32  LO register
count  output  4  remaining busy cycles, 0 when idle

Behaviour:
- Clock and reset: all state changes on the rising clk edge. Reset is synchronous and active-high: when reset is high at an edge, the block goes to IDLE, and busy=0, count=0, hi=0, lo=0, and the internal result registers are cleared.
- States:
  - IDLE: busy=0, count=0.
  - RUN: busy=1, count=remaining cycles.
- IDLE to RUN: at an edge with start=1 and op in 1..4:
  - Compute the result from src_a/src_b and hold it internally.
  - Load count with MULT_CYCLES (op 1,2) or DIV_CYCLES (op 3,4).
  - busy rises in the following cycle.
- start=1 with op outside 1..4: ignored.
- RUN behaviour:
  - count decrements by 1 each edge.
  - At the edge where count==1: hi/lo take the held result, count becomes 0, state returns to IDLE.
  - busy is therefore high for exactly N cycles.
  - hi/lo show their old values throughout RUN.
- Arithmetic:
  - mult: signed 32x32 product, hi = bits 63:32, lo = bits 31:0.
  - multu: the same, unsigned.
  - div: lo = signed quotient truncated toward zero, hi = remainder with the sign of the dividend.
  - divu: unsigned quotient and remainder.
  - Divide by zero (src_b==0): the countdown still runs for the full latency, and hi/lo are left unchanged at completion.
- mthi/mtlo: in IDLE with no start, op 5/6 writes src_a to hi/lo at the edge (single cycle, no busy).
- op 5/6 during RUN or during a start cycle: ignored. The stall protocol never lets this happen legally.
- Start during RUN: ignored. The countdown and held result are unaffected. The verifier flags this as a protocol violation.
- stall_md (combinational): md_in_d & (busy | start). This covers the issue cycle, before busy rises.
- mfhi/mflo: read hi/lo combinationally, subject to stall_md.
- count and busy are registered outputs; stall_md and hi/lo reads are glitch-free from the D/E pipeline view.
- Reset during RUN: aborts immediately, with no commit of the held result.
- Back-to-back: a new start is accepted at the edge immediately after the completion edge (the cycle in which busy=0).

Test Plan:
- Reset, then start, op=1, src_a=0xFFFFFFFE (-2), src_b=3 → busy=1 for 5 cycles, count 5→1, then hi=0xFFFFFFFF, lo=0xFFFFFFFA, busy=0.
- op=2 multu with 0xFFFFFFFF x 2 → after 5 cycles hi=0x00000001, lo=0xFFFFFFFE. Then op=3 div -7/2 → after 10 cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- mthi/mtlo setting hi=0x1234, lo=0x5678, then divu 10/0 → busy for 10 cycles, hi=0x1234 and lo=0x5678 unchanged at completion.
- md_in_d=1 held across a mult issue → stall_md=1 on the start cycle and all 5 busy cycles, 0 on the cycle after completion. With md_in_d=0, stall_md stays 0 throughout.
- Reset asserted at count=3 of a div → next cycle busy=0, count=0, hi=lo=0. A later mult completes normally.
- start with op=1 while busy (count=2), and op=5 while busy → both ignored: the original result commits on schedule and hi is not overwritten by src_a.
